// File: rtl/cc_unit.sv
// cc_unit: NZP condition codes with a save/restore stack and branch enable.
// Define CC_BEN_REG_EN to register o_BEN (one-cycle latency).
module cc_unit #(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_LD_CC,
  input  logic [DATA_W-1:0] i_Bus,
  input  logic              i_LD_Direct,
  input  logic [2:0]        i_NZP_In,
  input  logic              i_Push,
  input  logic              i_Pop,
  input  logic              i_ClrErr,
  input  logic [2:0]        i_IR_NZP,
  output logic [2:0]        o_NZP,
  output logic              o_BEN,
  output logic [DW-1:0]     o_Depth,
  output logic              o_Full,
  output logic              o_Empty,
  output logic              o_Err
);

  logic [2:0]    nzp_q, nzp_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [2:0]    stk_q [STACK_DEPTH];
  logic [2:0]    stk_d [STACK_DEPTH];

  logic          full, empty;
  logic          push_req, pop_req;
  logic          push_ok, pop_ok, err_set;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [2:0]    cls;
  logic          bus_n, bus_z;

  assign full  = (depth_q == DW'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  assign bus_n = i_Bus[DATA_W-1];
  assign bus_z = (i_Bus == '0);
  assign cls   = {bus_n, bus_z, ~bus_n & ~bus_z};

  // A simultaneous push and pop is treated as misuse: neither is honoured.
  assign push_req = i_Push & ~i_Pop;
  assign pop_req  = i_Pop & ~i_Push;
  assign push_ok  = push_req & ~full;
  assign pop_ok   = pop_req & ~empty;
  assign err_set  = (i_Push & i_Pop)
                  | (push_req & full)
                  | (pop_req & empty);

  assign wr_idx = IW'(depth_q);
  assign rd_idx = IW'(depth_q - DW'(1));

  always_comb begin
    nzp_d   = nzp_q;
    depth_d = depth_q;
    err_d   = err_q;
    stk_d   = stk_q;
    unique case (1'b1)
      pop_ok:      nzp_d = stk_q[rd_idx];
      i_LD_Direct: nzp_d = i_NZP_In;
      i_LD_CC:     nzp_d = cls;
      default:     nzp_d = nzp_q;
    endcase
    if (push_ok) begin
      stk_d[wr_idx] = nzp_q;
      depth_d       = depth_q + DW'(1);
    end else if (pop_ok) begin
      depth_d = depth_q - DW'(1);
    end
    if (err_set) begin
      err_d = 1'b1;
    end else if (i_ClrErr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      nzp_q   <= 3'b010;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      nzp_q   <= nzp_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is never reset; entries above depth are don't-care.
  always_ff @(posedge i_CLK) begin
    stk_q <= stk_d;
  end

`ifdef CC_BEN_REG_EN
  logic ben_q, ben_d;

  assign ben_d = |(i_IR_NZP & nzp_q);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      ben_q <= 1'b0;
    end else begin
      ben_q <= ben_d;
    end
  end

  assign o_BEN = ben_q;
`else
  assign o_BEN = |(i_IR_NZP & nzp_q);
`endif

  assign o_NZP   = nzp_q;
  assign o_Depth = depth_q;
  assign o_Full  = full;
  assign o_Empty = empty;
  assign o_Err   = err_q;

endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: directed vectors plus a queue-based model of cc_unit.
// Outputs are compared against the model on every falling clock edge.
module tb_cc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_cc, ld_dir, push, pop, clr;
  logic [15:0] bus;
  logic [2:0]  nzp_in, ir;
  logic [2:0]  nzp;
  logic        ben, full, empty, err;
  logic [2:0]  depth;

  int checks   = 0;
  int failures = 0;

  cc_unit #(.DATA_W(16), .STACK_DEPTH(DEPTH)) dut (
    .i_CLK(clk),
    .i_RST_N(rst_n),
    .i_LD_CC(ld_cc),
    .i_Bus(bus),
    .i_LD_Direct(ld_dir),
    .i_NZP_In(nzp_in),
    .i_Push(push),
    .i_Pop(pop),
    .i_ClrErr(clr),
    .i_IR_NZP(ir),
    .o_NZP(nzp),
    .o_BEN(ben),
    .o_Depth(depth),
    .o_Full(full),
    .o_Empty(empty),
    .o_Err(err)
  );

  always #5 clk = ~clk;

  logic [2:0] m_nzp;
  logic [2:0] m_stk[$];
  logic       m_err;
  logic       m_ben;
  logic       m_se, m_pe, m_po;
  logic [2:0] m_nx;

  function automatic logic [2:0] classify(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else                 return 3'b001;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nzp = 3'b010;
      m_stk.delete();
      m_err = 1'b0;
      m_ben = 1'b0;
    end else begin
      m_ben = |(ir & m_nzp);
      m_se  = 1'b0;
      m_pe  = 1'b0;
      m_po  = 1'b0;
      if (push && pop) m_se = 1'b1;
      else if (push) begin
        if (m_stk.size() == DEPTH) m_se = 1'b1;
        else                       m_pe = 1'b1;
      end else if (pop) begin
        if (m_stk.size() == 0) m_se = 1'b1;
        else                   m_po = 1'b1;
      end
      m_nx = m_nzp;
      if (m_po)        m_nx = m_stk.pop_back();
      else if (ld_dir) m_nx = nzp_in;
      else if (ld_cc)  m_nx = classify(bus);
      if (m_pe) m_stk.push_back(m_nzp);
      m_nzp = m_nx;
      if (m_se)     m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
  end

  function automatic logic exp_ben();
`ifdef CC_BEN_REG_EN
    return m_ben;
`else
    return |(ir & m_nzp);
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mdl_nzp",   {5'd0, nzp},   {5'd0, m_nzp});
    chk("mdl_depth", {5'd0, depth}, 8'(m_stk.size()));
    chk("mdl_full",  {7'd0, full},  {7'd0, m_stk.size() == DEPTH});
    chk("mdl_empty", {7'd0, empty}, {7'd0, m_stk.size() == 0});
    chk("mdl_err",   {7'd0, err},   {7'd0, m_err});
    chk("mdl_ben",   {7'd0, ben},   {7'd0, exp_ben()});
  end

  task automatic step(input logic lc, input logic [15:0] b,
                      input logic ld, input logic [2:0] ni,
                      input logic pu, input logic po, input logic cl);
    ld_cc  = lc;
    bus    = b;
    ld_dir = ld;
    nzp_in = ni;
    push   = pu;
    pop    = po;
    clr    = cl;
    @(posedge clk);
    @(negedge clk);
    #1;
    ld_cc  = 1'b0;
    ld_dir = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic ldcc(input logic [15:0] b);
    step(1'b1, b, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lddir(input logic [2:0] v);
    step(1'b0, 16'h0, 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input logic pu, input logic po, input logic cl);
    step(1'b0, 16'h0, 1'b0, 3'b000, pu, po, cl);
  endtask

  initial begin
    rst_n  = 1'b1;
    ld_cc  = 1'b0;
    ld_dir = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    bus    = 16'h0;
    nzp_in = 3'b000;
    ir     = 3'b000;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    chk("rst_nzp",   {5'd0, nzp},  8'h02);
    chk("rst_depth", {5'd0, depth}, 8'h00);
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_full",  {7'd0, full},  8'h00);
    chk("rst_err",   {7'd0, err},   8'h00);
    chk("rst_ben",   {7'd0, ben},   8'h00);

    ldcc(16'h8000); chk("cls_8000", {5'd0, nzp}, 8'h04);
    ldcc(16'h0000); chk("cls_0000", {5'd0, nzp}, 8'h02);
    ldcc(16'h0001); chk("cls_0001", {5'd0, nzp}, 8'h01);
    ldcc(16'h7FFF); chk("cls_7fff", {5'd0, nzp}, 8'h01);

    lddir(3'b001);
    ctl(1'b1, 1'b0, 1'b0); chk("lifo_d1", {5'd0, depth}, 8'h01);
    lddir(3'b100);
    ctl(1'b1, 1'b0, 1'b0); chk("lifo_d2", {5'd0, depth}, 8'h02);
    ctl(1'b0, 1'b1, 1'b0);
    chk("lifo_pop1", {5'd0, nzp}, 8'h04);
    chk("lifo_dp1",  {5'd0, depth}, 8'h01);
    ctl(1'b0, 1'b1, 1'b0);
    chk("lifo_pop2", {5'd0, nzp}, 8'h01);
    chk("lifo_dp0",  {5'd0, depth}, 8'h00);
    chk("lifo_err",  {7'd0, err}, 8'h00);

    for (int i = 0; i < 4; i++) ctl(1'b1, 1'b0, 1'b0);
    chk("full_4",   {7'd0, full}, 8'h01);
    chk("full_err", {7'd0, err},  8'h00);
    ctl(1'b1, 1'b0, 1'b0);
    chk("ovf_err",   {7'd0, err},   8'h01);
    chk("ovf_depth", {5'd0, depth}, 8'h04);
    ctl(1'b0, 1'b0, 1'b1);
    chk("clr_err", {7'd0, err}, 8'h00);
    for (int i = 0; i < 4; i++) ctl(1'b0, 1'b1, 1'b0);
    chk("drain_empty", {7'd0, empty}, 8'h01);

    step(1'b1, 16'hFFFF, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("unf_err", {7'd0, err}, 8'h01);
    chk("unf_nzp", {5'd0, nzp}, 8'h04);
    ctl(1'b0, 1'b1, 1'b1);
    chk("set_wins", {7'd0, err}, 8'h01);
    ctl(1'b0, 1'b0, 1'b1);
    chk("clr_err2", {7'd0, err}, 8'h00);

    ctl(1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("pp_err",   {7'd0, err},   8'h01);
    chk("pp_depth", {5'd0, depth}, 8'h01);
    chk("pp_nzp",   {5'd0, nzp},   8'h02);
    ctl(1'b0, 1'b1, 1'b1);
    chk("pp_pop", {5'd0, nzp}, 8'h04);

    lddir(3'b010);
    ir = 3'b011;
`ifdef CC_BEN_REG_EN
    ctl(1'b0, 1'b0, 1'b0);
`endif
    #1 chk("ben_011", {7'd0, ben}, 8'h01);
    ir = 3'b101;
`ifdef CC_BEN_REG_EN
    ctl(1'b0, 1'b0, 1'b0);
`endif
    #1 chk("ben_101", {7'd0, ben}, 8'h00);
    ir = 3'b000;

    step(1'b0, 16'h0, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
    chk("pd_nzp",   {5'd0, nzp},   8'h06);
    chk("pd_depth", {5'd0, depth}, 8'h01);
    ctl(1'b0, 1'b1, 1'b0);
    chk("pd_old", {5'd0, nzp}, 8'h02);
    ctl(1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0001, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    ctl(1'b1, 1'b1, 1'b0);
    chk("pre_rst_err", {7'd0, err}, 8'h01);
    ir = 3'b111;
    push = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_nzp",   {5'd0, nzp},   8'h02);
    chk("arst_depth", {5'd0, depth}, 8'h00);
    chk("arst_empty", {7'd0, empty}, 8'h01);
    chk("arst_full",  {7'd0, full},  8'h00);
    chk("arst_err",   {7'd0, err},   8'h00);
`ifdef CC_BEN_REG_EN
    chk("arst_ben", {7'd0, ben}, 8'h00);
`else
    chk("arst_ben", {7'd0, ben}, 8'h01);
`endif
    push = 1'b0;
    ir   = 3'b000;
    @(negedge clk);
    #1 rst_n = 1'b1;
    ldcc(16'h8000);
    chk("post_rst", {5'd0, nzp}, 8'h04);
    chk("post_dep", {5'd0, depth}, 8'h00);

    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_unit.md
CC_UNIT -- requirements
Module: cc_unit

Interface
REQ-001 Parameter DATA_W, default 16: width of i_Bus; legal range 2 to 64.
REQ-002 Parameter STACK_DEPTH, default 4: number of saved-NZP stack entries; legal range 1 to 16.
REQ-003 The port i_CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 The port i_RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 The port i_LD_CC  input  1  SHALL mean: load the condition codes from i_Bus.
REQ-006 The port i_Bus  input  DATA_W  SHALL carry the two's-complement value to classify.
REQ-007 The port i_LD_Direct  input  1  SHALL mean: load the condition codes verbatim from i_NZP_In (PSR write).
REQ-008 The port i_NZP_In  input  3  SHALL carry the direct-load value {N,Z,P}.
REQ-009 The port i_Push  input  1  SHALL mean: save the current o_NZP onto the stack (interrupt entry).
REQ-010 The port i_Pop  input  1  SHALL mean: restore o_NZP from the top of the stack (RTI).
REQ-011 The port i_ClrErr  input  1  SHALL clear o_Err.
REQ-012 The port i_IR_NZP  input  3  SHALL carry the branch condition field from the IR.
REQ-013 The port o_NZP  output  3  SHALL carry the current condition codes: N=bit 2, Z=bit 1, P=bit 0.
REQ-014 The port o_BEN  output  1  SHALL be the branch enable.
REQ-015 The port o_Depth  output  clog2(STACK_DEPTH+1)  SHALL give the number of valid stack entries.
REQ-016 The ports o_Full and o_Empty  output  1 each  SHALL flag o_Depth==STACK_DEPTH and o_Depth==0 respectively.
REQ-017 The port o_Err  output  1  SHALL be a sticky stack-misuse flag.

Function
REQ-018 Classification SHALL be: N = i_Bus[DATA_W-1]; Z = (i_Bus==0); P = !N && !Z; exactly one bit set.
REQ-019 o_NZP update priority SHALL be: accepted pop > i_LD_Direct > i_LD_CC > hold.
REQ-020 All o_NZP loads SHALL take effect one cycle after the request edge.
REQ-021 i_LD_Direct SHALL store non-one-hot values verbatim with no correction.
REQ-022 A push with !o_Full SHALL write the pre-edge o_NZP to stack[o_Depth] and increment o_Depth.
REQ-023 A push SHALL not alter o_NZP; a simultaneous i_LD_CC or i_LD_Direct still updates o_NZP.
REQ-024 A pop with !o_Empty SHALL load o_NZP from stack[o_Depth-1] and decrement o_Depth.
REQ-025 A push while o_Full SHALL be dropped, leave stack and o_Depth unchanged, and set o_Err.
REQ-026 A pop while o_Empty SHALL be dropped and set o_Err; lower-priority loads proceed that cycle.
REQ-027 Simultaneous i_Push and i_Pop SHALL both be dropped and set o_Err; lower-priority loads proceed.
REQ-028 o_Err SHALL stay at 1 until i_ClrErr; when a set and i_ClrErr coincide, set wins.
REQ-029 The stack SHALL be LIFO, with no wrap-around; entries above o_Depth are don't-care.
REQ-030 Default o_BEN SHALL be combinational: |(i_IR_NZP & o_NZP).

Reset
REQ-031 Asserting i_RST_N low SHALL immediately force o_NZP=3'b010, o_Depth=0, o_Empty=1, o_Full=0, o_Err=0, and o_BEN=0 when registered.
REQ-032 Reset mid-push or mid-pop SHALL abort the operation; the first post-reset edge SHALL act only on the inputs present at that edge.
REQ-033 Stack storage contents SHALL not require reset.

Configuration
REQ-034 With CC_BEN_REG_EN defined, o_BEN SHALL be a register loaded every edge with |(i_IR_NZP & o_NZP) using the pre-edge o_NZP, giving one-cycle latency.
REQ-035 Without CC_BEN_REG_EN, o_BEN SHALL be combinational per REQ-030 and the module SHALL contain no BEN flop.

Verification
REQ-036 Reset, then i_LD_CC with i_Bus=16'h8000, 16'h0000, 16'h0001, 16'h7FFF -> o_NZP sequence 100, 010, 001, 001.
REQ-037 Load NZP=001, push; load NZP=100, push; pop, pop -> o_NZP 100 then 001, o_Depth 2,1,0, o_Err=0.
REQ-038 STACK_DEPTH=4: five pushes -> o_Full=1 after four, o_Err=1 after fifth, o_Depth=4; then i_ClrErr -> o_Err=0.
REQ-039 On an empty stack: pop with i_LD_CC and i_Bus=16'hFFFF in the same cycle -> o_Err=1, o_NZP=100.
REQ-040 o_NZP=010 and i_IR_NZP=011 -> o_BEN=1 (same cycle without the macro, next cycle with it); i_IR_NZP=101 -> o_BEN=0.
REQ-041 Push with i_LD_Direct=3'b110 in the same cycle -> stack holds the old value, o_NZP=110; then i_RST_N low mid-sequence -> o_NZP=010, o_Depth=0 with no clock edge.
